// File: rtl/branch_decode_unit.sv
// Branch decode stage: resolves LDB/BRZ/JMP, drives fetch redirect pulses and
// squashes the SHADOW instructions already fetched behind each taken redirect.
module branch_decode_unit #(
  parameter int unsigned SHADOW = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] instruction_val,
  input  logic       zero_flag,
  output logic       branch_ctrl,
  output logic [7:0] branch_val,
  output logic       jump_ctrl,
  output logic [7:0] jump_val,
  output logic       exec_valid,
  output logic [8:0] exec_instr,
  output logic [7:0] redirect_count
);

  localparam logic [2:0] OP_LDB      = 3'b001;
  localparam logic [2:0] OP_BRZ      = 3'b010;
  localparam logic [2:0] OP_JMP      = 3'b011;
  localparam logic [1:0] SQUASH_LOAD = 2'(SHADOW);

  logic [7:0] r_branch;
  logic       r_branch_ctrl;
  logic       r_jump_ctrl;
  logic [7:0] r_jump_val;
  logic       r_exec_valid;
  logic [8:0] r_exec_instr;
  logic [7:0] r_redirect_count;
  logic [1:0] r_squash;

  logic [2:0] w_opcode;
  logic [5:0] w_imm6;
  logic       w_live;
  logic       w_take_brz;
  logic       w_take_jmp;
  logic       w_redirect;

  assign w_opcode   = instruction_val[8:6];
  assign w_imm6     = instruction_val[5:0];
  // Anything sampled while the shadow is being flushed is dead on arrival.
  assign w_live     = (r_squash == 2'd0);
  assign w_take_brz = w_live && (w_opcode == OP_BRZ) && zero_flag;
  assign w_take_jmp = w_live && (w_opcode == OP_JMP);
  assign w_redirect = w_take_brz || w_take_jmp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_branch         <= 8'h00;
      r_branch_ctrl    <= 1'b0;
      r_jump_ctrl      <= 1'b0;
      r_jump_val       <= 8'h00;
      r_exec_valid     <= 1'b0;
      r_exec_instr     <= 9'h000;
      r_redirect_count <= 8'h00;
      r_squash         <= 2'd1;
    end else begin
      r_branch_ctrl <= w_take_brz;
      r_jump_ctrl   <= w_take_jmp;
      r_exec_valid  <= w_live;
      if (w_live) r_exec_instr <= instruction_val;
      if (w_live && (w_opcode == OP_LDB)) r_branch <= {{2{w_imm6[5]}}, w_imm6};
      if (w_take_jmp) r_jump_val <= {2'b00, w_imm6};
      if (w_redirect) begin
        r_squash <= SQUASH_LOAD;
        if (r_redirect_count != 8'hFF) r_redirect_count <= r_redirect_count + 8'd1;
      end else if (!w_live) begin
        r_squash <= r_squash - 2'd1;
      end
    end
  end

  assign branch_ctrl    = r_branch_ctrl;
  assign branch_val     = r_branch;
  assign jump_ctrl      = r_jump_ctrl;
  assign jump_val       = r_jump_val;
  assign exec_valid     = r_exec_valid;
  assign exec_instr     = r_exec_instr;
  assign redirect_count = r_redirect_count;

endmodule
